// File: rtl/fd_scan_controller.sv
// FAST feature-detection scan sequencer: centre read, circle neighbour and comparator indices.
// Optional CONTINUOUS_EN: restart at the first pixel after frameDone instead of idling.
module fd_scan_controller #(
  parameter int COLS       = 180,
  parameter int ROWS       = 120,
  parameter int BORDER     = 3,
  parameter int ADJ_COUNT  = 16,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 15,
  parameter int IDX_W      = 5
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] refAddr,
  output logic              readen,
  output logic [IDX_W-1:0]  adjNumber,
  output logic              adjValid,
  output logic [IDX_W-1:0]  regAddr,
  output logic              regValid,
  output logic              pixelDone,
  output logic              frameDone,
  output logic              busy
);

  localparam int INNER = COLS - 2 * BORDER;
  localparam int CW = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [ADDR_W-1:0] FIRST_A =
    ADDR_W'(BORDER * COLS + BORDER);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'((ROWS - 1 - BORDER) * COLS + COLS - 1 - BORDER);
  localparam logic [ADDR_W-1:0] WRAP_A = ADDR_W'(2 * BORDER + 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(INNER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ADJ_COUNT - 1);
  localparam logic [DW-1:0]     DRN_LAST = DW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ADJ,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       col_q, col_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DW-1:0]       drn_q, drn_d;
  logic [RD_LATENCY-1:0] pv_q;
  logic [RD_LATENCY-1:0][IDX_W-1:0] pi_q;

  logic              pix_end;
  logic              last_pix;
  logic              adj_on;
  logic [IDX_W-1:0]  adj_num;

  assign last_pix = (addr_q == LAST_A);
  assign adj_on   = (state_q == S_ADJ);
  assign adj_num  = adj_on ? idx_q : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    idx_d   = idx_q;
    drn_d   = drn_q;
    pix_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // start is taken even while stalled; LOAD itself waits
        if (start) begin
          state_d = S_LOAD;
          addr_d  = FIRST_A;
          col_d   = '0;
        end
      end
      S_LOAD: begin
        if (!stall) begin
          state_d = S_ADJ;
          idx_d   = '0;
        end
      end
      S_ADJ: begin
        if (!stall) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
            idx_d   = '0;
            drn_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drn_q == DRN_LAST) begin
            pix_end = 1'b1;
            if (last_pix) begin
`ifdef CONTINUOUS_EN
              state_d = S_LOAD;
              addr_d  = FIRST_A;
              col_d   = '0;
`else
              state_d = S_IDLE;
`endif
            end else begin
              state_d = S_LOAD;
              if (col_q == COL_LAST) begin
                addr_d = addr_q + WRAP_A;
                col_d  = '0;
              end else begin
                addr_d = addr_q + ADDR_W'(1);
                col_d  = col_q + CW'(1);
              end
            end
          end else begin
            drn_d = drn_q + DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      drn_q   <= drn_d;
    end
  end

  // neighbour index delayed to line up with memory data
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pv_q <= '0;
      pi_q <= '0;
    end else if (!stall) begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pv_q[i] <= pv_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
      pv_q[0] <= adj_on;
      pi_q[0] <= adj_num;
    end
  end

  assign refAddr   = addr_q;
  assign readen    = (state_q == S_LOAD) && !stall;
  assign adjNumber = adj_num;
  assign adjValid  = adj_on && !stall;
  assign regAddr   = pi_q[RD_LATENCY-1];
  assign regValid  = pv_q[RD_LATENCY-1] && !stall;
  assign pixelDone = pix_end;
  assign frameDone = pix_end && last_pix;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fd_scan_controller.sv
// Bench for fd_scan_controller: directed scenarios on the default frame
// plus model-checked small frames with random stall and stray start pulses.
module tb_fd_scan_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                nReset;
  logic [2:0]          start;
  logic [2:0]          stall;
  logic [2:0][14:0]    ref_o;
  logic [2:0][4:0]     an_o;
  logic [2:0][4:0]     ra_o;
  logic [2:0]          rd_o, av_o, rv_o, pd_o, fd_o, bz_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit rd, av, rv, pd, fd;
    int ref_a, an, ra;
  } exp_t;

  fd_scan_controller u0 (
    .clock(clock), .nReset(nReset), .start(start[0]), .stall(stall[0]),
    .refAddr(ref_o[0]), .readen(rd_o[0]), .adjNumber(an_o[0]),
    .adjValid(av_o[0]), .regAddr(ra_o[0]), .regValid(rv_o[0]),
    .pixelDone(pd_o[0]), .frameDone(fd_o[0]), .busy(bz_o[0])
  );

  fd_scan_controller #(.COLS(10), .ROWS(8), .BORDER(3)) u1 (
    .clock(clock), .nReset(nReset), .start(start[1]), .stall(stall[1]),
    .refAddr(ref_o[1]), .readen(rd_o[1]), .adjNumber(an_o[1]),
    .adjValid(av_o[1]), .regAddr(ra_o[1]), .regValid(rv_o[1]),
    .pixelDone(pd_o[1]), .frameDone(fd_o[1]), .busy(bz_o[1])
  );

  fd_scan_controller #(
    .COLS(16), .ROWS(12), .BORDER(2), .ADJ_COUNT(5), .RD_LATENCY(3)
  ) u2 (
    .clock(clock), .nReset(nReset), .start(start[2]), .stall(stall[2]),
    .refAddr(ref_o[2]), .readen(rd_o[2]), .adjNumber(an_o[2]),
    .adjValid(av_o[2]), .regAddr(ra_o[2]), .regValid(rv_o[2]),
    .pixelDone(pd_o[2]), .frameDone(fd_o[2]), .busy(bz_o[2])
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    start  = '0;
    stall  = '0;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
  endtask

  task automatic test_reset();
    logic [30:0] obs;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      obs = {ref_o[0], an_o[0], ra_o[0], rd_o[0], av_o[0],
             rv_o[0], pd_o[0], fd_o[0], bz_o[0]};
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_idle c=%0d got=%h want=0", c, obs);
      end
      next_cycle();
    end
  endtask

  task automatic test_first_pixel();
    logic [30:0] obs, want;
    bit rd, av, rv, pd;
    int an, ra;
    do_reset();
    start[0] = 1'b1;
    @(negedge clock);
    total++;
    if (bz_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL first_busy_at_start got=%b want=0", bz_o[0]);
    end
    next_cycle();
    start[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      rd = (c == 1) || (c == 20);
      av = (c >= 2) && (c <= 17);
      an = av ? c - 2 : 0;
      rv = (c >= 4) && (c <= 19);
      ra = rv ? c - 4 : 0;
      pd = (c == 19);
      want = {(c == 20) ? 15'd544 : 15'd543, 5'(an), 5'(ra),
              rd, av, rv, pd, 1'b0, 1'b1};
      obs = {ref_o[0], an_o[0], ra_o[0], rd_o[0], av_o[0],
             rv_o[0], pd_o[0], fd_o[0], bz_o[0]};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL first_pixel c=%0d got=%h want=%h", c, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_row_wrap();
    int prev = -1;
    bit found = 0;
    int col;
    do_reset();
    start[0] = 1'b1;
    next_cycle();
    start[0] = 1'b0;
    for (int c = 0; c < 200 * 19 && !found; c++) begin
      @(negedge clock);
      if (rd_o[0]) begin
        col = int'(ref_o[0]) % 180;
        total++;
        if (col < 3 || col > 176) begin
          bad++;
          $display("FAIL wrap_col addr=%0d col=%0d want 3..176",
                   ref_o[0], col);
        end
        if (ref_o[0] == 15'd723) begin
          found = 1;
          total++;
          if (prev != 716) begin
            bad++;
            $display("FAIL wrap_prev got=%0d want=716", prev);
          end
        end
        prev = int'(ref_o[0]);
      end
      next_cycle();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wrap_reach got=none want=723");
    end
  endtask

  task automatic test_stall_directed();
    int q[$];
    int sc = 0;
    bit seen = 0, released = 0, done = 0;
    do_reset();
    start[0] = 1'b1;
    next_cycle();
    start[0] = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      stall[0] = (sc > 0);
      @(negedge clock);
      if (stall[0]) begin
        total++;
        if ({rd_o[0], av_o[0], rv_o[0], pd_o[0], fd_o[0]} !== 5'b0 ||
            an_o[0] !== 5'd8 || ref_o[0] !== 15'd543) begin
          bad++;
          $display("FAIL stall_hold strobes=%b an=%0d ref=%0d want 0/8/543",
                   {rd_o[0], av_o[0], rv_o[0], pd_o[0], fd_o[0]},
                   an_o[0], ref_o[0]);
        end
        sc--;
        if (sc == 0) released = 1;
      end else begin
        if (released) begin
          released = 0;
          total++;
          if (av_o[0] !== 1'b1 || an_o[0] !== 5'd8) begin
            bad++;
            $display("FAIL stall_resume av=%b an=%0d want 1/8",
                     av_o[0], an_o[0]);
          end
        end
        if (av_o[0] && an_o[0] == 5'd7 && !seen) begin
          seen = 1;
          sc = 5;
        end
        if (rv_o[0]) q.push_back(int'(ra_o[0]));
        if (pd_o[0]) done = 1;
      end
      next_cycle();
    end
    stall[0] = 1'b0;
    total++;
    if (!seen || !done) begin
      bad++;
      $display("FAIL stall_progress seen=%0d done=%0d want 1/1", seen, done);
    end
    total++;
    if (q.size() != 16) begin
      bad++;
      $display("FAIL stall_reg_count got=%0d want=16", q.size());
    end
    for (int k = 0; k < q.size(); k++) begin
      total++;
      if (q[k] != k) begin
        bad++;
        $display("FAIL stall_reg_seq k=%0d got=%0d want=%0d", k, q[k], k);
      end
    end
  endtask

  task automatic test_frame(input int d, input int cols, input int rows,
                            input int border, input int adj, input int lat,
                            input int stall_pct);
    exp_t q[$];
    exp_t e;
    int npix = 0;
    int i = 0;
    int pds = 0;
    int cyc = 0;
    bit st;
    logic [4:0] obs_s, want_s;
    int first_a = border * cols + border;
    for (int r = border; r <= rows - 1 - border; r++) begin
      for (int c = border; c <= cols - 1 - border; c++) begin
        npix++;
        for (int t = 0; t <= adj + lat; t++) begin
          int k = t - 1 - lat;
          e.ref_a = r * cols + c;
          e.rd = (t == 0);
          e.av = (t >= 1) && (t <= adj);
          e.an = e.av ? t - 1 : 0;
          e.rv = (k >= 0) && (k < adj);
          e.ra = e.rv ? k : 0;
          e.pd = (t == adj + lat);
          e.fd = e.pd && (r == rows - 1 - border) &&
                 (c == cols - 1 - border);
          q.push_back(e);
        end
      end
    end
    do_reset();
    start[d] = 1'b1;
    stall[d] = ($urandom_range(99) < stall_pct);
    @(negedge clock);
    total++;
    if (bz_o[d] !== 1'b0) begin
      bad++;
      $display("FAIL frame%0d_busy_start got=%b want=0", d, bz_o[d]);
    end
    next_cycle();
    while (i < q.size() && cyc < 20 * q.size() + 100) begin
      start[d] = ($urandom_range(7) == 0);
      st = ($urandom_range(99) < stall_pct);
      stall[d] = st;
      @(negedge clock);
      e = q[i];
      obs_s = {rd_o[d], av_o[d], rv_o[d], pd_o[d], fd_o[d]};
      want_s = st ? 5'b0 : {e.rd, e.av, e.rv, e.pd, e.fd};
      total++;
      if (obs_s !== want_s) begin
        bad++;
        $display("FAIL frame%0d_strobes i=%0d st=%0d got=%b want=%b",
                 d, i, st, obs_s, want_s);
      end
      total++;
      if (ref_o[d] !== 15'(e.ref_a) || an_o[d] !== 5'(e.an) ||
          ra_o[d] !== 5'(e.ra) || bz_o[d] !== 1'b1) begin
        bad++;
        $display("FAIL frame%0d_values i=%0d got=%0d/%0d/%0d/%b want=%0d/%0d/%0d/1",
                 d, i, ref_o[d], an_o[d], ra_o[d], bz_o[d],
                 e.ref_a, e.an, e.ra);
      end
      if (!st) begin
        i++;
        if (pd_o[d]) pds++;
      end
      next_cycle();
      cyc++;
    end
    start[d] = 1'b0;
    stall[d] = 1'b0;
    total++;
    if (i < q.size()) begin
      bad++;
      $display("FAIL frame%0d_timeout got=%0d want=%0d", d, i, q.size());
    end
    total++;
    if (pds != npix) begin
      bad++;
      $display("FAIL frame%0d_pixels got=%0d want=%0d", d, pds, npix);
    end
    @(negedge clock);
    total++;
`ifdef CONTINUOUS_EN
    if (rd_o[d] !== 1'b1 || ref_o[d] !== 15'(first_a) || bz_o[d] !== 1'b1) begin
      bad++;
      $display("FAIL frame%0d_restart got=%b/%0d/%b want=1/%0d/1",
               d, rd_o[d], ref_o[d], bz_o[d], first_a);
    end
`else
    if (rd_o[d] !== 1'b0 || bz_o[d] !== 1'b0) begin
      bad++;
      $display("FAIL frame%0d_idle got=%b/%b want=0/0 first=%0d",
               d, rd_o[d], bz_o[d], first_a);
    end
`endif
    next_cycle();
  endtask

  task automatic test_small_frame();
    test_frame(1, 10, 8, 3, 16, 2, 0);
  endtask

  task automatic test_random_stall();
    test_frame(2, 16, 12, 2, 5, 3, 30);
  endtask

  task automatic test_reset_mid_scan();
    logic [30:0] obs;
    do_reset();
    start[0] = 1'b1;
    next_cycle();
    start[0] = 1'b0;
    repeat (4) next_cycle();
    @(negedge clock);
    total++;
    if (av_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_in_adj got=%b want=1", av_o[0]);
    end
    #2;
    nReset = 1'b0;
    #1;
    obs = {ref_o[0], an_o[0], ra_o[0], rd_o[0], av_o[0],
           rv_o[0], pd_o[0], fd_o[0], bz_o[0]};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL midrst_async got=%h want=0", obs);
    end
    next_cycle();
    nReset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      total++;
      if (bz_o[0] !== 1'b0 || rd_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL midrst_stay_idle c=%0d got=%b/%b want=0/0",
                 c, bz_o[0], rd_o[0]);
      end
      next_cycle();
    end
  endtask

  initial begin
    nReset = 1'b0;
    start  = '0;
    stall  = '0;
    test_reset();
    test_first_pixel();
    test_row_wrap();
    test_stall_directed();
    test_small_frame();
    test_random_stall();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
